// File: rtl/fp_result_arbiter_if.sv
// Handshake bundle between the FP execution units, the result arbiter and writeback.
// The arbiter uses the slave view; the units and writeback together use the master view.
interface fp_result_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       req_sign;
    logic [NUM_REQ*11-1:0]    req_exp;
    logic [NUM_REQ*52-1:0]    req_mant;
    logic [NUM_REQ-1:0]       req_nan;
    logic [NUM_REQ-1:0]       req_inf;
    logic [NUM_REQ-1:0]       req_zero;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [63:0]              out_fp;
    logic [TAG_W-1:0]         out_tag;
    logic [1:0]               out_src;
    logic [1:0]               out_count;

    modport slave (
        input  req_valid, req_sign, req_exp, req_mant, req_nan, req_inf, req_zero, req_tag,
        input  out_ready,
        output req_ready, out_valid, out_fp, out_tag, out_src, out_count
    );

    modport master (
        output req_valid, req_sign, req_exp, req_mant, req_nan, req_inf, req_zero, req_tag,
        output out_ready,
        input  req_ready, out_valid, out_fp, out_tag, out_src, out_count
    );
endinterface

// File: rtl/fp_result_arbiter.sv
// Round-robin arbiter that packs one FP unit result per cycle into IEEE-754 double
// format and buffers it in a 2-entry FIFO toward writeback.
module fp_result_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    fp_result_arbiter_if.slave bus
);
    localparam int unsigned NR = NUM_REQ;

    typedef struct packed {
        logic [63:0]      fp;
        logic [TAG_W-1:0] tag;
        logic [1:0]       src;
    } entry_t;

    entry_t             head_q;
    entry_t             tail_q;
    entry_t             push_entry;
    logic [1:0]         count_q;
    logic [1:0]         rr_ptr;
    logic [1:0]         rr_next;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    int unsigned        gsel;
    logic               push;
    logic               pop;

    logic               sel_sign;
    logic [10:0]        sel_exp;
    logic [51:0]        sel_mant;
    logic               sel_nan;
    logic               sel_inf;
    logic               sel_zero;
    logic [TAG_W-1:0]   sel_tag;

    // Search rr_ptr, rr_ptr+1, ... and take the first valid requester.
    always_comb begin
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        gsel  = 0;
        idx   = 0;
        if (!rst && count_q != 2'd2) begin
            for (int unsigned k = 0; k < NR; k++) begin
                idx = (32'(rr_ptr) + k) % NR;
                for (int unsigned i = 0; i < NR; i++) begin
                    if (!found && i == idx && bus.req_valid[i]) begin
                        found    = 1'b1;
                        grant[i] = 1'b1;
                        gsel     = i;
                    end
                end
            end
        end
    end

    assign rr_next = 2'((gsel + 1) % NR);
    assign push    = found;
    assign pop     = (count_q != 2'd0) && bus.out_ready;

    always_comb begin
        sel_sign = 1'b0;
        sel_exp  = '0;
        sel_mant = '0;
        sel_nan  = 1'b0;
        sel_inf  = 1'b0;
        sel_zero = 1'b0;
        sel_tag  = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (grant[i]) begin
                sel_sign = bus.req_sign[i];
                sel_exp  = bus.req_exp[i*11 +: 11];
                sel_mant = bus.req_mant[i*52 +: 52];
                sel_nan  = bus.req_nan[i];
                sel_inf  = bus.req_inf[i];
                sel_zero = bus.req_zero[i];
                sel_tag  = bus.req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        push_entry     = '0;
        push_entry.tag = sel_tag;
        push_entry.src = 2'(gsel);
        if (sel_nan)
            push_entry.fp = 64'h7FF8_0000_0000_0001;
        else if (sel_inf)
            push_entry.fp = {sel_sign, 11'h7FF, 52'h0};
        else if (sel_zero)
            push_entry.fp = {sel_sign, 11'h000, 52'h0};
        else
            push_entry.fp = {sel_sign, sel_exp, sel_mant};
    end

    // head_q is the FIFO head and doubles as the output register, so it keeps
    // its last value once drained; tail_q only holds the second entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            rr_ptr  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            if (push)
                rr_ptr <= rr_next;
            if (pop && count_q == 2'd2)
                head_q <= tail_q;
            if (push) begin
                if (count_q == 2'd0 || (count_q == 2'd1 && pop))
                    head_q <= push_entry;
                else
                    tail_q <= push_entry;
            end
            if (push && !pop)
                count_q <= count_q + 2'd1;
            else if (pop && !push)
                count_q <= count_q - 2'd1;
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_fp    = head_q.fp;
    assign bus.out_tag   = head_q.tag;
    assign bus.out_src   = head_q.src;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_fp_result_arbiter.sv
// Directed bench for fp_result_arbiter: packing, round-robin order, backpressure and reset.
module tb_fp_result_arbiter;
    localparam int NUM_REQ = 3;
    localparam int TAG_W   = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    fp_result_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus_if ();

    fp_result_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic s, input logic [10:0] e,
                           input logic [51:0] m, input logic [2:0] nif, input logic [3:0] t);
        bus_if.req_sign[i]           = s;
        bus_if.req_exp[i*11 +: 11]   = e;
        bus_if.req_mant[i*52 +: 52]  = m;
        bus_if.req_nan[i]            = nif[2];
        bus_if.req_inf[i]            = nif[1];
        bus_if.req_zero[i]           = nif[0];
        bus_if.req_tag[i*4 +: 4]     = t;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus_if.req_valid = '1;
        bus_if.req_sign  = '0;
        bus_if.req_exp   = '0;
        bus_if.req_mant  = '0;
        bus_if.req_nan   = '0;
        bus_if.req_inf   = '0;
        bus_if.req_zero  = '0;
        bus_if.req_tag   = '0;
        bus_if.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ready", 64'(bus_if.req_ready), 64'h0);
        check("rst_valid", 64'(bus_if.out_valid), 64'h0);
        check("rst_count", 64'(bus_if.out_count), 64'h0);
        check("rst_fp",    bus_if.out_fp, 64'h0);
        check("rst_tag",   64'(bus_if.out_tag), 64'h0);
        check("rst_src",   64'(bus_if.out_src), 64'h0);

        // Single requester 1
        rst = 1'b0;
        bus_if.req_valid = 3'b010;
        bus_if.out_ready = 1'b1;
        set_req(1, 1'b1, 11'h400, 52'h8000000000000, 3'b000, 4'd5);
        settle();
        check("t1_ready", 64'(bus_if.req_ready), 64'h2);
        tick();
        bus_if.req_valid = '0;
        check("t1_valid", 64'(bus_if.out_valid), 64'h1);
        check("t1_fp",    bus_if.out_fp, 64'hC008000000000000);
        check("t1_tag",   64'(bus_if.out_tag), 64'h5);
        check("t1_src",   64'(bus_if.out_src), 64'h1);
        tick();
        check("t1_drain", 64'(bus_if.out_count), 64'h0);

        // Round robin from reset, all three requesters valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int unsigned i = 0; i < 3; i++)
            set_req(i, 1'b0, 11'h3FF, 52'h0, 3'b000, 4'(i + 1));
        bus_if.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            settle();
            check("rr_ready", 64'(bus_if.req_ready), 64'(3'b001 << (k % 3)));
            tick();
            check("rr_src",   64'(bus_if.out_src), 64'(k % 3));
            check("rr_count", 64'(bus_if.out_count), 64'h1);
        end
        bus_if.req_valid = '0;
        tick();
        check("rr_drain", 64'(bus_if.out_count), 64'h0);

        // Backpressure with requesters 0 and 2
        bus_if.out_ready = 1'b0;
        set_req(0, 1'b0, 11'h3FF, 52'h1, 3'b000, 4'hA);
        set_req(2, 1'b0, 11'h3FF, 52'h2, 3'b000, 4'hB);
        bus_if.req_valid = 3'b101;
        settle();
        check("bp_ready0", 64'(bus_if.req_ready), 64'h1);
        tick();
        check("bp_count1", 64'(bus_if.out_count), 64'h1);
        settle();
        check("bp_ready2", 64'(bus_if.req_ready), 64'h4);
        tick();
        check("bp_count2", 64'(bus_if.out_count), 64'h2);
        settle();
        check("bp_full_ready", 64'(bus_if.req_ready), 64'h0);
        tick();
        check("bp_hold_count", 64'(bus_if.out_count), 64'h2);
        check("bp_hold_tag",   64'(bus_if.out_tag), 64'hA);
        check("bp_hold_src",   64'(bus_if.out_src), 64'h0);
        bus_if.out_ready = 1'b1;
        settle();
        check("bp_no_bypass", 64'(bus_if.req_ready), 64'h0);
        tick();
        check("bp_pop_count", 64'(bus_if.out_count), 64'h1);
        check("bp_pop_src",   64'(bus_if.out_src), 64'h2);
        check("bp_pop_tag",   64'(bus_if.out_tag), 64'hB);
        settle();
        check("bp_resume", 64'(bus_if.req_ready), 64'h1);
        tick();
        check("bp_resume_src",   64'(bus_if.out_src), 64'h0);
        check("bp_resume_count", 64'(bus_if.out_count), 64'h1);

        // Fill to 2, then reset mid-transfer
        bus_if.out_ready = 1'b0;
        settle();
        check("rs_ready", 64'(bus_if.req_ready), 64'h4);
        tick();
        check("rs_full",  64'(bus_if.out_count), 64'h2);
        check("rs_valid", 64'(bus_if.out_valid), 64'h1);
        rst = 1'b1;
        bus_if.req_valid = 3'b111;
        bus_if.out_ready = 1'b1;
        settle();
        check("rs_ready_in_rst", 64'(bus_if.req_ready), 64'h0);
        tick();
        check("rs_valid0", 64'(bus_if.out_valid), 64'h0);
        check("rs_count0", 64'(bus_if.out_count), 64'h0);
        check("rs_fp0",    bus_if.out_fp, 64'h0);
        rst = 1'b0;
        settle();
        check("rs_first_grant", 64'(bus_if.req_ready), 64'h1);
        tick();
        check("rs_first_src", 64'(bus_if.out_src), 64'h0);
        bus_if.req_valid = '0;
        tick();
        check("rs_drain", 64'(bus_if.out_count), 64'h0);

        // Flag priority and passthrough on requester 0
        bus_if.req_valid = 3'b001;
        set_req(0, 1'b1, 11'h123, 52'h456, 3'b111, 4'h1);
        tick();
        check("pk_nan", bus_if.out_fp, 64'h7FF8000000000001);
        set_req(0, 1'b1, 11'h123, 52'h456, 3'b010, 4'h2);
        tick();
        check("pk_inf", bus_if.out_fp, 64'hFFF0000000000000);
        set_req(0, 1'b1, 11'h123, 52'h456, 3'b001, 4'h3);
        tick();
        check("pk_zero", bus_if.out_fp, 64'h8000000000000000);
        set_req(0, 1'b0, 11'h000, 52'h1, 3'b000, 4'h4);
        tick();
        check("pk_subnormal", bus_if.out_fp, 64'h0000000000000001);
        set_req(0, 1'b0, 11'h7FF, 52'h5, 3'b000, 4'h6);
        tick();
        check("pk_exp_max",   bus_if.out_fp, 64'h7FF0000000000005);
        check("pk_exp_tag",   64'(bus_if.out_tag), 64'h6);
        check("pk_exp_count", 64'(bus_if.out_count), 64'h1);
        bus_if.req_valid = '0;
        tick();
        check("pk_drain",      64'(bus_if.out_valid), 64'h0);
        check("pk_hold_after", bus_if.out_fp, 64'h7FF0000000000005);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_result_arbiter.md
# fp_result_arbiter

Shares one 64-bit result-packing path among up to four floating-point execution units (adder, multiplier, divider, sqrt). Each unit presents a finished sign, encoded 11-bit exponent field, 52-bit mantissa field and special-value flags. A round-robin arbiter grants one requester per cycle and packs the winner into IEEE-754 double format. The packed word is pushed into a 2-entry output FIFO with a valid/ready handshake toward writeback. All rounding, normalisation and overflow decisions are made upstream; this block only arbitrates, packs and buffers.

## Interface
- NUM_REQ, 3, number of requesters; legal range 2..4
- TAG_W, 4, width of the per-operation tag carried alongside each result
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i holds a result
- req_ready  out  NUM_REQ  one-hot grant; request i is accepted on the edge where req_valid[i] && req_ready[i]
- req_sign  in  NUM_REQ  sign bit per requester
- req_exp  in  NUM_REQ*11  exponent field; requester i occupies bits [11i+10:11i]
- req_mant  in  NUM_REQ*52  mantissa field; requester i occupies bits [52i+51:52i]
- req_nan, req_inf, req_zero  in  NUM_REQ each  special-value flags
- req_tag  in  NUM_REQ*TAG_W  opaque tag, returned unchanged
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts the head on this edge
- out_fp  out  64  packed double at the FIFO head
- out_tag  out  TAG_W  tag of the head entry
- out_src  out  2  index of the requester that produced the head entry
- out_count  out  2  FIFO occupancy, 0..2

## Operation
- Packing of the granted requester, with priority nan > inf > zero > normal:
  - nan → 64'h7FF8000000000001 (sign ignored)
  - inf → {sign, 11'h7FF, 52'h0}
  - zero → {sign, 11'h000, 52'h0}; -0 is preserved
  - otherwise → {sign, exp, mant} verbatim, including exp=0 subnormals and exp=7FF with no flag set
- Arbitration: round-robin pointer rr_ptr, reset to 0.
  - Search order is rr_ptr, rr_ptr+1, … modulo NUM_REQ. The first requester with req_valid set wins.
  - After an accepted grant to requester g, rr_ptr becomes (g+1) mod NUM_REQ. rr_ptr is unchanged on idle cycles.
- Grant condition: out_count < 2 and at least one req_valid is high.
  - req_ready is combinational from req_valid, rr_ptr and out_count.
  - At most one req_ready bit is high, and only for a requester whose req_valid is high.
- FIFO: 2 entries, in order. Each entry holds {fp[63:0], tag, src}.
  - Push on grant; pop on out_valid && out_ready.
- Occupancy transitions:
  - push only: +1
  - pop only: -1
  - both (count 1): stays 1; the new entry becomes the head on the following cycle
  - both (count 2): impossible, because no grant is issued at count 2
- Full (out_count = 2): all req_ready are 0 regardless of out_ready, so there is no same-cycle bypass.
- Empty: out_valid = 0; out_fp, out_tag and out_src hold their last values and are don't-care.
- Requester inputs are sampled only on the accept edge. Changes to requester inputs while not granted have no effect.

## Timing
- Latency: an accept at edge N gives out_valid = 1 with the packed data after edge N. Minimum one cycle.
- Throughput: one result per cycle sustained while out_ready = 1 and requests are present.
- A head entry stays stable (out_fp, out_tag, out_src) while out_valid && !out_ready.
- Reset, applied at any time including mid-transfer:
  - out_valid = 0, out_count = 0, rr_ptr = 0
  - out_fp = 0, out_tag = 0, out_src = 0
  - FIFO contents discarded
  - req_ready = 0 during every cycle in which rst is high
- First grant is possible on the first cycle after rst deasserts.

## Test plan
- Single requester 1 presents sign=1, exp=0x400, mant=0x8000000000000, tag=5, with out_ready=1. Expect req_ready[1] in the same cycle, and one cycle later out_valid=1, out_fp=0xC008000000000000, out_tag=5, out_src=1.
- All three requesters valid continuously from reset, with out_ready=1. Expect grant order 0,1,2,0,1,2, one per cycle, and out_count steady at 1.
- Flag priority: requester 0 with nan=inf=zero=1, sign=1 → out_fp=0x7FF8000000000001. Then inf only, sign=1 → 0xFFF0000000000000. Then zero only, sign=1 → 0x8000000000000000.
- Backpressure: out_ready=0 with requesters 0 and 2 valid. Expect two accepts (0 then 2), then out_count=2 and req_ready=0. Raise out_ready: expect the entries to drain in order 0, 2, and granting to resume.
- Reset at out_count=2 with out_valid high. On the next cycle expect out_valid=0, out_count=0 and rr_ptr=0; the first post-reset grant with all requesters valid goes to requester 0.
- Subnormal passthrough: exp=0, mant=1, sign=0, no flags → out_fp=0x0000000000000001.
